// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the instruction cache: bus field positions and refill FSM states.
package icache_ctrl_pkg;

    localparam int ICACHE_HIT    = 32;
    localparam int ICACHE_DATA_W = 32;

    typedef enum logic {
        IC_IDLE   = 1'b0,
        IC_REFILL = 1'b1
    } ic_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped icache: combinational read,
// one word-write port, a line-install port and a whole-array invalidate.
module icache_array #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 22,
    localparam int IDX_W         = $clog2(LINES),
    localparam int OFF_W         = $clog2(WORDS_PER_LINE)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [OFF_W-1:0] rd_off_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [OFF_W-1:0] wr_off_i,
    input  logic [31:0]      wr_data_i,
    input  logic             fill_en_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  logic             inval_all_i
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS_PER_LINE];

    // Invalidate has priority over install so a line filled under a pending
    // invalidate never becomes visible.
    always_ff @(posedge Clk) begin
        if (!Rst)             valid_q <= '0;
        else if (inval_all_i) valid_q <= '0;
        else if (fill_en_i)   valid_q[wr_idx_i] <= 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (wr_en_i)   data_q[wr_idx_i][wr_off_i] <= wr_data_i;
        if (fill_en_i) tag_q[wr_idx_i] <= fill_tag_i;
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped icache controller: same-cycle hit lookup for IF, and an
// in-order word-by-word line refill over a req/ack memory handshake.
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Icache_bus_out,
    output logic [32:0] Icache_bus_in,
    input  logic        i_inval,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data,
    output logic        o_busy
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

    logic [OFF_W-1:0] f_off;
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             unused_ok;

    assign f_off     = Icache_bus_out[OFF_W+1:2];
    assign f_idx     = Icache_bus_out[IDX_W+OFF_W+1:OFF_W+2];
    assign f_tag     = Icache_bus_out[31:IDX_W+OFF_W+2];
    assign unused_ok = ^Icache_bus_out[1:0];

    ic_state_e        state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             req_q, req_d;
    logic             pend_q, pend_d;
    logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
    logic [TAG_W-1:0] cap_tag_q, cap_tag_d;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             line_hit, hit;
    logic             wr_en, fill_en, inval_all;

    icache_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_array (
        .Clk         (Clk),
        .Rst         (Rst),
        .rd_idx_i    (f_idx),
        .rd_off_i    (f_off),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_en_i     (wr_en),
        .wr_idx_i    (cap_idx_q),
        .wr_off_i    (cnt_q),
        .wr_data_i   (i_mem_data),
        .fill_en_i   (fill_en),
        .fill_tag_i  (cap_tag_q),
        .inval_all_i (inval_all)
    );

    assign line_hit = rd_valid && (rd_tag == f_tag);
    assign hit      = Rst && (state_q == IC_IDLE) && !i_inval && line_hit;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q   <= IC_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            req_q     <= 1'b0;
            pend_q    <= 1'b0;
            cap_idx_q <= '0;
            cap_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            pend_q    <= pend_d;
            cap_idx_q <= cap_idx_d;
            cap_tag_q <= cap_tag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        req_d     = req_q;
        pend_d    = pend_q;
        cap_idx_d = cap_idx_q;
        cap_tag_d = cap_tag_q;
        wr_en     = 1'b0;
        fill_en   = 1'b0;
        inval_all = 1'b0;
        unique case (state_q)
            IC_IDLE: begin
                pend_d    = 1'b0;
                inval_all = i_inval;
                // Only a genuine miss refills; an inval over a resident line just drops it.
                if (!line_hit) begin
                    state_d   = IC_REFILL;
                    req_d     = 1'b1;
                    cnt_d     = '0;
                    cap_idx_d = f_idx;
                    cap_tag_d = f_tag;
                    addr_d    = {f_tag, f_idx, {OFF_W{1'b0}}, 2'b00};
                end
            end
            IC_REFILL: begin
                if (i_inval) pend_d = 1'b1;
                if (i_mem_ack) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == OFF_W'(WORDS_PER_LINE - 1)) begin
                        state_d = IC_IDLE;
                        req_d   = 1'b0;
                        pend_d  = 1'b0;
                        if (pend_q || i_inval) inval_all = 1'b1;
                        else                   fill_en   = 1'b1;
                    end else begin
                        addr_d = addr_q + 32'd4;
                    end
                end
            end
            default: state_d = IC_IDLE;
        endcase
    end

    assign Icache_bus_in = {hit, rd_data};
    assign o_mem_req     = req_q;
    assign o_mem_addr    = addr_q;
    assign o_busy        = (state_q == IC_REFILL);

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: reset, cold/conflict misses, hits, wait
// states, invalidate (idle, mid-refill, on final ack) and reset mid-refill.
module tb_icache_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] Icache_bus_out;
    logic [32:0] Icache_bus_in;
    logic        i_inval;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
    logic        o_busy;

    int n_tot = 0;
    int n_bad = 0;

    icache_ctrl #(.LINES(64), .WORDS_PER_LINE(4)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Icache_bus_out (Icache_bus_out),
        .Icache_bus_in  (Icache_bus_in),
        .i_inval        (i_inval),
        .o_mem_req      (o_mem_req),
        .o_mem_addr     (o_mem_addr),
        .i_mem_ack      (i_mem_ack),
        .i_mem_data     (i_mem_data),
        .o_busy         (o_busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Memory side of one refill; inval_w pulses i_inval with that word's ack.
    task automatic refill(input logic [31:0] base, input logic [31:0] d0, input int gap,
                          input int inval_w, input int nwords);
        for (int w = 0; w < nwords; w++) begin
            for (int g = 0; g < gap; g++) begin
                i_mem_ack = 1'b0;
                tick();
                chk("wait_req", o_mem_req, 1'b1);
                chk("wait_addr", o_mem_addr, base + 32'(4 * w));
            end
            chk("rf_req", o_mem_req, 1'b1);
            chk("rf_addr", o_mem_addr, base + 32'(4 * w));
            chk("rf_nohit", Icache_bus_in[32], 1'b0);
            i_mem_ack  = 1'b1;
            i_mem_data = d0 + 32'(w);
            i_inval    = (w == inval_w);
            tick();
            i_inval = 1'b0;
        end
        i_mem_ack = 1'b0;
        if (nwords == 4) begin
            chk("rf_done_req", o_mem_req, 1'b0);
            chk("rf_done_busy", o_busy, 1'b0);
        end
    endtask

    task automatic expect_start(input logic [31:0] base);
        tick();
        chk("start_req", o_mem_req, 1'b1);
        chk("start_busy", o_busy, 1'b1);
        chk("start_addr", o_mem_addr, base);
    endtask

    initial begin
        Rst = 1'b0; Icache_bus_out = 32'h40; i_inval = 1'b0;
        i_mem_ack = 1'b0; i_mem_data = 32'h0;

        // Reset held two cycles
        tick(); tick();
        chk("rst_hit", Icache_bus_in[32], 1'b0);
        chk("rst_req", o_mem_req, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_addr", o_mem_addr, 32'h0);

        // Cold miss on 0x40
        Rst = 1'b1; #1;
        chk("cold_miss", Icache_bus_in[32], 1'b0);
        expect_start(32'h40);
        refill(32'h40, 32'hA0, 0, -1, 4);
        chk("cold_fill_hit", Icache_bus_in, {1'b1, 32'hA0});

        // Hit in same line
        Icache_bus_out = 32'h48; #1;
        chk("hit_48", Icache_bus_in, {1'b1, 32'hA2});
        chk("hit_noreq", o_mem_req, 1'b0);
        tick();
        chk("hit_48_hold", Icache_bus_in, {1'b1, 32'hA2});
        chk("hit_noreq2", o_mem_req, 1'b0);

        // Invalidate in IDLE, then refill with wait states
        i_inval = 1'b1; #1;
        chk("inval_cyc_hit", Icache_bus_in[32], 1'b0);
        tick();
        i_inval = 1'b0; #1;
        chk("post_inval_miss", Icache_bus_in[32], 1'b0);
        chk("post_inval_busy", o_busy, 1'b0);
        expect_start(32'h40);
        refill(32'h40, 32'hA0, 2, -1, 4);
        chk("gap_hit_48", Icache_bus_in, {1'b1, 32'hA2});
        Icache_bus_out = 32'h40; #1;
        chk("gap_hit_40", Icache_bus_in, {1'b1, 32'hA0});

        // Conflict miss: 0x440 maps to the same index
        Icache_bus_out = 32'h440; #1;
        chk("conf_miss", Icache_bus_in[32], 1'b0);
        expect_start(32'h440);
        refill(32'h440, 32'hB0, 0, -1, 4);
        chk("conf_hit", Icache_bus_in, {1'b1, 32'hB0});
        Icache_bus_out = 32'h40; #1;
        chk("evicted_miss", Icache_bus_in[32], 1'b0);
        expect_start(32'h40);

        // Invalidate during 2nd word, then on the final ack
        refill(32'h40, 32'hC0, 0, 1, 4);
        chk("inv_mid_miss", Icache_bus_in[32], 1'b0);
        expect_start(32'h40);
        refill(32'h40, 32'hC0, 0, 3, 4);
        chk("inv_last_miss", Icache_bus_in[32], 1'b0);
        expect_start(32'h40);

        // Reset after two acks
        refill(32'h40, 32'hD0, 0, -1, 2);
        Rst = 1'b0;
        tick();
        chk("midrst_req", o_mem_req, 1'b0);
        chk("midrst_busy", o_busy, 1'b0);
        chk("midrst_hit", Icache_bus_in[32], 1'b0);
        Rst = 1'b1; #1;
        chk("midrst_miss", Icache_bus_in[32], 1'b0);
        expect_start(32'h40);
        refill(32'h40, 32'hE0, 0, -1, 4);
        chk("refill_hit", Icache_bus_in, {1'b1, 32'hE0});
        Icache_bus_out = 32'h4C; #1;
        chk("refill_hit_w3", Icache_bus_in, {1'b1, 32'hE3});

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
